// File: rtl/mux_tree_pipe_if.sv
// Valid/ready bundle for the pipelined mux tree: channel bus and select
// in, selected channel out, with handshakes on both sides.
interface mux_tree_pipe_if #(
    parameter int NUM_IN = 64,
    parameter int DATA_W = 8
);
    localparam int SEL_W = $clog2(NUM_IN);

    logic [NUM_IN-1:0][DATA_W-1:0] in;
    logic [SEL_W-1:0]              sel;
    logic                          in_valid;
    logic                          in_ready;
    logic [DATA_W-1:0]             out_data;
    logic                          out_valid;
    logic                          out_ready;
    logic                          sel_err;

    modport master (
        output in, sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid, sel_err
    );

    modport slave (
        input  in, sel, in_valid, out_ready,
        output in_ready, out_data, out_valid, sel_err
    );
endinterface

// File: rtl/mux_tree_pipe.sv
// NUM_IN:1 binary mux tree, registered every PIPE_EVERY levels, valid/ready.
// Define MUX_TREE_PIPE_SEL_CHECK_EN to carry an out-of-range select flag.
module mux_tree_pipe #(
    parameter int NUM_IN     = 64,
    parameter int DATA_W     = 8,
    parameter int PIPE_EVERY = 2
) (
    input logic           clk,
    input logic           rst_n,
    mux_tree_pipe_if.slave bus
);
    localparam int SEL_W  = $clog2(NUM_IN);
    localparam int LEVELS = SEL_W;
    localparam int NSTAGE = (LEVELS + PIPE_EVERY - 1) / PIPE_EVERY;

    logic [NSTAGE-1:0] vld;
    logic [NSTAGE-1:0] rdy;

    // Ready ripples back from the consumer; a local keeps the chain acyclic.
    always_comb begin
        logic r;
        r = bus.out_ready;
        for (int s = NSTAGE - 1; s >= 0; s--) begin
            r      = !vld[s] || r;
            rdy[s] = r;
        end
    end

    for (genvar s = 0; s < NSTAGE; s++) begin : g_stg
        localparam int LO = s * PIPE_EVERY;
        localparam int HI = ((s + 1) * PIPE_EVERY > LEVELS) ?
                            LEVELS : (s + 1) * PIPE_EVERY;
        localparam int NI = 1 << (LEVELS - LO);
        localparam int NO = 1 << (LEVELS - HI);
        localparam int SI = SEL_W - LO;
        localparam bit LAST = (s == NSTAGE - 1);

        logic [NI-1:0][DATA_W-1:0] din;
        logic [SI-1:0]             sin;
        logic                      vin;
        logic [NO-1:0][DATA_W-1:0] dnx;
        logic [NO-1:0][DATA_W-1:0] node_q;
        logic                      valid_q;

        if (s == 0) begin : g_src
            // Leaves beyond NUM_IN are zero, so out-of-range selects read 0.
            always_comb begin
                din             = '0;
                din[NUM_IN-1:0] = bus.in;
            end
            assign sin = bus.sel;
            assign vin = bus.in_valid;
        end else begin : g_src
            assign din = g_stg[s-1].node_q;
            assign sin = g_stg[s-1].g_fwd.sel_q;
            assign vin = vld[s-1];
        end

        always_comb begin
            logic [NI-1:0][DATA_W-1:0] t;
            t = din;
            for (int l = 0; l < HI - LO; l++) begin
                for (int j = 0; j < (NI >> (l + 1)); j++) begin
                    t[j] = sin[l] ? t[2*j+1] : t[2*j];
                end
            end
            dnx = t[NO-1:0];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                node_q  <= '0;
            end else if (rdy[s]) begin
                valid_q <= vin;
                if (vin) begin
                    node_q <= dnx;
                end
            end
        end

        assign vld[s] = valid_q;

        if (!LAST) begin : g_fwd
            logic [SEL_W-HI-1:0] sel_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sel_q <= '0;
                end else if (rdy[s] && vin) begin
                    sel_q <= sin[SI-1:HI-LO];
                end
            end
        end

`ifdef MUX_TREE_PIPE_SEL_CHECK_EN
        logic ein;
        logic err_q;

        if (s == 0) begin : g_esrc
            assign ein = 32'(bus.sel) >= NUM_IN;
        end else begin : g_esrc
            assign ein = g_stg[s-1].err_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                err_q <= 1'b0;
            end else if (rdy[s] && vin) begin
                err_q <= ein;
            end
        end
`endif
    end

    assign bus.in_ready  = rdy[0];
    assign bus.out_valid = vld[NSTAGE-1];
    assign bus.out_data  = g_stg[NSTAGE-1].node_q[0];

`ifdef MUX_TREE_PIPE_SEL_CHECK_EN
    assign bus.sel_err = vld[NSTAGE-1] & g_stg[NSTAGE-1].err_q;
`else
    assign bus.sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Scoreboard bench for mux_tree_pipe: three configurations (64/2, 40/1, 2/1)
// with directed vectors plus a short random run on the 2-input tree.
module tb_mux_tree_pipe;
`ifdef MUX_TREE_PIPE_SEL_CHECK_EN
    localparam bit SEL_CHK = 1'b1;
`else
    localparam bit SEL_CHK = 1'b0;
`endif

    typedef struct {
        logic [7:0] d;
        logic       e;
        int         t;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    bit   c_lat;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];
    exp_t ea, eb, ec, ecp, ep;

    mux_tree_pipe_if #(.NUM_IN(64), .DATA_W(8)) ba();
    mux_tree_pipe_if #(.NUM_IN(40), .DATA_W(8)) bb();
    mux_tree_pipe_if #(.NUM_IN(2),  .DATA_W(8)) bc();

    mux_tree_pipe #(.NUM_IN(64), .DATA_W(8), .PIPE_EVERY(2)) u_a (
        .clk(clk), .rst_n(rst_n), .bus(ba)
    );
    mux_tree_pipe #(.NUM_IN(40), .DATA_W(8), .PIPE_EVERY(1)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(bb)
    );
    mux_tree_pipe #(.NUM_IN(2), .DATA_W(8), .PIPE_EVERY(1)) u_c (
        .clk(clk), .rst_n(rst_n), .bus(bc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic send_a(input int s, input logic [7:0] d,
                          input bit lat, output int waits);
        waits = 0;
        ba.sel = 6'(s);
        ba.in_valid = 1'b1;
        @(negedge clk);
        while (!ba.in_ready && waits < 100) begin
            waits++;
            @(negedge clk);
        end
        checks++;
        if (!ba.in_ready) begin
            fails++;
            $display("FAIL a_accept_timeout sel=%0d got in_ready=0 required 1", s);
        end else begin
            ep.d = d;
            ep.e = 1'b0;
            ep.t = lat ? cyc + 3 : -1;
            qa.push_back(ep);
        end
        @(posedge clk);
        #1 ba.in_valid = 1'b0;
    endtask

    task automatic send_b(input int s, input logic [7:0] d, input bit e);
        int waits = 0;
        bb.sel = 6'(s);
        bb.in_valid = 1'b1;
        @(negedge clk);
        while (!bb.in_ready && waits < 100) begin
            waits++;
            @(negedge clk);
        end
        checks++;
        if (!bb.in_ready) begin
            fails++;
            $display("FAIL b_accept_timeout sel=%0d got in_ready=0 required 1", s);
        end else begin
            ep.d = d;
            ep.e = e;
            ep.t = cyc + 6;
            qb.push_back(ep);
        end
        @(posedge clk);
        #1 bb.in_valid = 1'b0;
    endtask

    logic [7:0] a_hold;
    bit         a_held;

    always @(negedge clk) begin
        if (!rst_n) begin
            a_held = 1'b0;
        end else begin
            if (a_held && ba.out_valid) begin
                checks++;
                if (ba.out_data !== a_hold) begin
                    fails++;
                    $display("FAIL a_stall_hold got %h required %h",
                             ba.out_data, a_hold);
                end
            end
            if (ba.out_valid && ba.out_ready) begin
                checks++;
                if (qa.size() == 0) begin
                    fails++;
                    $display("FAIL a_spurious got %h required no output",
                             ba.out_data);
                end else begin
                    ea = qa.pop_front();
                    if ({ba.out_data, ba.sel_err} !== {ea.d, ea.e}) begin
                        fails++;
                        $display("FAIL a_data got %h/%b required %h/%b",
                                 ba.out_data, ba.sel_err, ea.d, ea.e);
                    end
                    if (ea.t >= 0) begin
                        checks++;
                        if (cyc != ea.t) begin
                            fails++;
                            $display("FAIL a_latency got cycle %0d required %0d",
                                     cyc, ea.t);
                        end
                    end
                end
            end
            a_held = ba.out_valid && !ba.out_ready;
            a_hold = ba.out_data;
        end
    end

    always @(negedge clk) begin
        if (rst_n && bb.out_valid && bb.out_ready) begin
            checks++;
            if (qb.size() == 0) begin
                fails++;
                $display("FAIL b_spurious got %h required no output",
                         bb.out_data);
            end else begin
                eb = qb.pop_front();
                if ({bb.out_data, bb.sel_err} !== {eb.d, eb.e}) begin
                    fails++;
                    $display("FAIL b_data got %h/%b required %h/%b",
                             bb.out_data, bb.sel_err, eb.d, eb.e);
                end
                checks++;
                if (cyc != eb.t) begin
                    fails++;
                    $display("FAIL b_latency got cycle %0d required %0d",
                             cyc, eb.t);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && bc.in_valid && bc.in_ready) begin
            ecp.d = bc.sel ? 8'hC3 : 8'h3C;
            ecp.e = 1'b0;
            ecp.t = c_lat ? cyc + 1 : -1;
            qc.push_back(ecp);
        end
    end

    always @(negedge clk) begin
        if (rst_n && bc.out_valid && bc.out_ready) begin
            checks++;
            if (qc.size() == 0) begin
                fails++;
                $display("FAIL c_spurious got %h required no output",
                         bc.out_data);
            end else begin
                ec = qc.pop_front();
                if ({bc.out_data, bc.sel_err} !== {ec.d, ec.e}) begin
                    fails++;
                    $display("FAIL c_data got %h/%b required %h/%b",
                             bc.out_data, bc.sel_err, ec.d, ec.e);
                end
                if (ec.t >= 0) begin
                    checks++;
                    if (cyc != ec.t) begin
                        fails++;
                        $display("FAIL c_latency got cycle %0d required %0d",
                                 cyc, ec.t);
                    end
                end
            end
        end
    end

    initial begin
        int w;
        int wsum;
        int w5, w6, w7, w8;

        for (int i = 0; i < 64; i++) ba.in[i] = 8'(8'h40 + i);
        for (int i = 0; i < 40; i++) bb.in[i] = 8'(8'h80 + i);
        bc.in[0] = 8'h3C;
        bc.in[1] = 8'hC3;
        ba.sel = '0; ba.in_valid = 1'b0; ba.out_ready = 1'b1;
        bb.sel = '0; bb.in_valid = 1'b0; bb.out_ready = 1'b1;
        bc.sel = '0; bc.in_valid = 1'b0; bc.out_ready = 1'b1;
        c_lat = 1'b0;
        rst_n = 1'b0;

        #2;
        checks++;
        if ({ba.out_valid, ba.out_data, ba.in_ready, ba.sel_err} !== 11'b0_00000000_1_0) begin
            fails++;
            $display("FAIL reset_state got v=%b d=%h r=%b e=%b required 0/00/1/0",
                     ba.out_valid, ba.out_data, ba.in_ready, ba.sel_err);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Three items in flight, then reset drops them all.
        ba.out_ready = 1'b0;
        send_a(1, 8'h41, 1'b0, w);
        send_a(2, 8'h42, 1'b0, w);
        send_a(3, 8'h43, 1'b0, w);
        rst_n = 1'b0;
        #1;
        checks++;
        if (ba.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL rst_out_valid got %b required 0", ba.out_valid);
        end
        checks++;
        if (ba.out_data !== 8'h00) begin
            fails++;
            $display("FAIL rst_out_data got %h required 00", ba.out_data);
        end
        checks++;
        if (ba.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_in_ready got %b required 1", ba.in_ready);
        end
        qa.delete();
        ba.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        send_a(37, 8'h65, 1'b1, w);
        repeat (6) @(posedge clk);
        #1;

        wsum = 0;
        for (int i = 0; i < 64; i++) begin
            send_a(i, 8'(8'h40 + i), 1'b1, w);
            wsum += w;
        end
        checks++;
        if (wsum != 0) begin
            fails++;
            $display("FAIL stream_in_ready got %0d stall cycles required 0", wsum);
        end
        repeat (6) @(posedge clk);
        #1;

        fork
            begin
                send_a(5, 8'h45, 1'b0, w5);
                send_a(6, 8'h46, 1'b0, w6);
                send_a(7, 8'h47, 1'b0, w7);
                send_a(8, 8'h48, 1'b0, w8);
            end
            begin
                repeat (2) @(posedge clk);
                #1 ba.out_ready = 1'b0;
                repeat (2) @(posedge clk);
                @(negedge clk);
                checks++;
                if (!(ba.out_valid && ba.out_data == 8'h45)) begin
                    fails++;
                    $display("FAIL bp_hold got v=%b d=%h required 1/45",
                             ba.out_valid, ba.out_data);
                end
                repeat (2) @(posedge clk);
                #1 ba.out_ready = 1'b1;
            end
        join
        checks++;
        if (w8 == 0) begin
            fails++;
            $display("FAIL bp_in_ready_drop got 0 stall cycles required >0");
        end
        repeat (8) @(posedge clk);
        #1;

        send_b(39, 8'hA7, 1'b0);
        send_b(45, 8'h00, SEL_CHK);
        send_b(0,  8'h80, 1'b0);
        send_b(32, 8'hA0, 1'b0);
        send_b(63, 8'h00, SEL_CHK);
        repeat (10) @(posedge clk);
        #1;

        c_lat = 1'b1;
        bc.sel = 1'b1;
        bc.in_valid = 1'b1;
        @(posedge clk);
        #1 bc.sel = 1'b0;
        @(posedge clk);
        #1 bc.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 c_lat = 1'b0;

        repeat (3000) begin
            @(posedge clk);
            #1;
            bc.in_valid  = 1'($urandom_range(0, 1));
            bc.sel       = 1'($urandom_range(0, 1));
            bc.out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk);
        #1;
        bc.in_valid  = 1'b0;
        bc.out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;

        checks++;
        if (qa.size() != 0) begin
            fails++;
            $display("FAIL a_drain got %0d pending required 0", qa.size());
        end
        checks++;
        if (qb.size() != 0) begin
            fails++;
            $display("FAIL b_drain got %0d pending required 0", qb.size());
        end
        checks++;
        if (qc.size() != 0) begin
            fails++;
            $display("FAIL c_drain got %0d pending required 0", qc.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end
endmodule
